// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter between the CPU MEM stage and an external
// loader/debug requester. The CPU has priority, bounded by a starvation counter.
module dmem_arbiter #(
    parameter int DSIZE    = 16,
    parameter int ASIZE    = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cpu_req_i,
    input  logic             cpu_wen_i,
    input  logic [ASIZE-1:0] cpu_addr_i,
    input  logic [DSIZE-1:0] cpu_wdata_i,
    output logic [DSIZE-1:0] cpu_rdata_o,
    output logic             cpu_stall_o,
    input  logic             ext_req_i,
    input  logic             ext_wen_i,
    input  logic [ASIZE-1:0] ext_addr_i,
    input  logic [DSIZE-1:0] ext_wdata_i,
    output logic             ext_gnt_o,
    output logic             ext_rvalid_o,
    output logic [DSIZE-1:0] ext_rdata_o,
    output logic             mem_wen_o,
    output logic [ASIZE-1:0] mem_addr_o,
    output logic [DSIZE-1:0] mem_wdata_o,
    input  logic [DSIZE-1:0] mem_rdata_i
);

    localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

    typedef enum logic [1:0] {
        S_CPU,
        S_EXT,
        S_EXT_RD
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    wait_cnt_q, wait_cnt_d;
    logic             ext_wen_q, ext_wen_d;
    logic [ASIZE-1:0] ext_addr_q, ext_addr_d;
    logic [DSIZE-1:0] ext_wdata_q, ext_wdata_d;
    logic             cpu_rd_q, cpu_rd_d;
    logic [DSIZE-1:0] cpu_rdata_q, cpu_rdata_d;
    logic             go_ext;
    logic             cpu_issue;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_CPU;
            wait_cnt_q  <= '0;
            ext_wen_q   <= 1'b0;
            ext_addr_q  <= '0;
            ext_wdata_q <= '0;
            cpu_rd_q    <= 1'b0;
            cpu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            ext_wen_q   <= ext_wen_d;
            ext_addr_q  <= ext_addr_d;
            ext_wdata_q <= ext_wdata_d;
            cpu_rd_q    <= cpu_rd_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        ext_wen_d    = ext_wen_q;
        ext_addr_d   = ext_addr_q;
        ext_wdata_d  = ext_wdata_q;
        go_ext       = 1'b0;
        cpu_issue    = 1'b0;
        cpu_stall_o  = 1'b0;
        ext_gnt_o    = 1'b0;
        ext_rvalid_o = 1'b0;
        ext_rdata_o  = '0;
        mem_wen_o    = 1'b0;
        mem_addr_o   = cpu_addr_i;
        mem_wdata_o  = cpu_wdata_i;

        unique case (state_q)
            S_EXT: begin
                mem_wen_o   = ext_wen_q;
                mem_addr_o  = ext_addr_q;
                mem_wdata_o = ext_wdata_q;
                ext_gnt_o   = 1'b1;
                cpu_stall_o = cpu_req_i;
                state_d     = ext_wen_q ? S_CPU : S_EXT_RD;
            end
            default: begin
                // S_EXT_RD returns ext data while the CPU owns the port again
                if (state_q == S_EXT_RD) begin
                    ext_rvalid_o = 1'b1;
                    ext_rdata_o  = mem_rdata_i;
                end
                cpu_issue = cpu_req_i;
                mem_wen_o = cpu_req_i & cpu_wen_i;
                go_ext    = ext_req_i & (~cpu_req_i | (wait_cnt_q == WAIT_MAX));
                if (go_ext) begin
                    state_d     = S_EXT;
                    ext_wen_d   = ext_wen_i;
                    ext_addr_d  = ext_addr_i;
                    ext_wdata_d = ext_wdata_i;
                    wait_cnt_d  = '0;
                end else begin
                    state_d = S_CPU;
                    if (ext_req_i & cpu_req_i) begin
                        if (wait_cnt_q != WAIT_MAX) begin
                            wait_cnt_d = wait_cnt_q + 1'b1;
                        end
                    end else begin
                        wait_cnt_d = '0;
                    end
                end
            end
        endcase

        // Keep the memory port quiet while reset is held
        if (rst_i) begin
            mem_wen_o   = 1'b0;
            mem_addr_o  = '0;
            mem_wdata_o = '0;
        end

        cpu_rd_d    = cpu_issue & ~cpu_wen_i;
        cpu_rdata_d = cpu_rd_q ? mem_rdata_i : cpu_rdata_q;
    end

    assign cpu_rdata_o = cpu_rd_q ? mem_rdata_i : cpu_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, corner sequences and a
// randomized run against a slot-level reference model.
module tb_dmem_arbiter;

    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_clr = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_wen = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic        ext_req = 1'b0;
    logic        ext_wen = 1'b0;
    logic [15:0] ext_addr = '0;
    logic [15:0] ext_wdata = '0;

    logic [15:0] cpu_rdata, ext_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_stall, ext_gnt, ext_rvalid, mem_wen;
    logic [15:0] cpu_rdata0, ext_rdata0, mem_addr0, mem_wdata0, mem_rdata0;
    logic        cpu_stall0, ext_gnt0, ext_rvalid0, mem_wen0;

    logic [15:0] mem4 [0:255];
    logic [15:0] mem0 [0:255];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DSIZE(16), .ASIZE(16), .MAX_WAIT(MW)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .cpu_req_i(cpu_req), .cpu_wen_i(cpu_wen),
        .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
        .cpu_rdata_o(cpu_rdata), .cpu_stall_o(cpu_stall),
        .ext_req_i(ext_req), .ext_wen_i(ext_wen),
        .ext_addr_i(ext_addr), .ext_wdata_i(ext_wdata),
        .ext_gnt_o(ext_gnt), .ext_rvalid_o(ext_rvalid), .ext_rdata_o(ext_rdata),
        .mem_wen_o(mem_wen), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    dmem_arbiter #(.DSIZE(16), .ASIZE(16), .MAX_WAIT(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst),
        .cpu_req_i(cpu_req), .cpu_wen_i(cpu_wen),
        .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
        .cpu_rdata_o(cpu_rdata0), .cpu_stall_o(cpu_stall0),
        .ext_req_i(ext_req), .ext_wen_i(ext_wen),
        .ext_addr_i(ext_addr), .ext_wdata_i(ext_wdata),
        .ext_gnt_o(ext_gnt0), .ext_rvalid_o(ext_rvalid0), .ext_rdata_o(ext_rdata0),
        .mem_wen_o(mem_wen0), .mem_addr_o(mem_addr0),
        .mem_wdata_o(mem_wdata0), .mem_rdata_i(mem_rdata0)
    );

    // Data memories with one-cycle registered read
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem4[i] <= '0;
        end else if (mem_wen) begin
            mem4[mem_addr[7:0]] <= mem_wdata;
        end
        mem_rdata <= mem4[mem_addr[7:0]];
    end

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem0[i] <= '0;
        end else if (mem_wen0) begin
            mem0[mem_addr0[7:0]] <= mem_wdata0;
        end
        mem_rdata0 <= mem0[mem_addr0[7:0]];
    end

    function automatic logic [15:0] b16(input logic b);
        return {15'd0, b};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        cr, cw;
        logic [15:0] ca, cd;
        logic        er, ew;
        logic [15:0] ea, ed;
        logic        gnt, stall, rv;
        logic [15:0] erd;
        logic        mwen;
        logic [15:0] maddr, crd;
    } vec_t;

    vec_t tbl [15];

    function automatic vec_t mk(
        input logic cr, input logic cw, input logic [15:0] ca, input logic [15:0] cd,
        input logic er, input logic ew, input logic [15:0] ea, input logic [15:0] ed,
        input logic gnt, input logic stall, input logic rv, input logic [15:0] erd,
        input logic mwen, input logic [15:0] maddr, input logic [15:0] crd);
        vec_t v;
        v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
        v.er = er; v.ew = ew; v.ea = ea; v.ed = ed;
        v.gnt = gnt; v.stall = stall; v.rv = rv; v.erd = erd;
        v.mwen = mwen; v.maddr = maddr; v.crd = crd;
        return v;
    endfunction

    // Reference model state (slot view of the shared port)
    logic        slot, slot_wen, eret, cret, n_slot, n_eret, n_cret, was_slot, e_stall;
    logic [15:0] slot_addr, slot_wd, eret_d, cret_d, clast, n_eret_d, n_cret_d;
    logic [15:0] shadow [0:255];
    int          lost;

    initial begin
        // Reset with a CPU write request present: memory port must stay idle
        cpu_req = 1'b1; cpu_wen = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 16'hDEAD;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("rst_mem_wen", b16(mem_wen), 16'h0);
        chk("rst_gnt", b16(ext_gnt), 16'h0);
        chk("rst_stall", b16(cpu_stall), 16'h0);
        chk("rst_rvalid", b16(ext_rvalid), 16'h0);
        chk("rst_ext_rdata", ext_rdata, 16'h0);
        chk("rst_cpu_rdata", cpu_rdata, 16'h0);
        chk("rst0_mem_wen", b16(mem_wen0), 16'h0);
        chk("rst0_rvalid", b16(ext_rvalid0), 16'h0);
        chk("rst0_ext_rdata", ext_rdata0, 16'h0);
        chk("rst0_cpu_rdata", cpu_rdata0, 16'h0);
        chk("rst0_mem_addr", mem_addr0, 16'h0);
        @(posedge clk); #1;
        rst = 1'b0; mem_clr = 1'b0;
        cpu_req = 1'b0; cpu_wen = 1'b0; cpu_addr = '0; cpu_wdata = '0;

        tbl[0]  = mk(1'b1, 1'b1, 16'h20, 16'h1234, 1'b0, 1'b0, 16'h0, 16'h0,
                     1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h20, 16'h0);
        tbl[1]  = mk(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 16'h10, 16'hBEEF,
                     1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
        tbl[2]  = mk(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 16'h10, 16'hBEEF,
                     1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 16'h10, 16'h0);
        tbl[3]  = mk(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h10, 16'h0,
                     1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
        tbl[4]  = mk(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h10, 16'h0,
                     1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h10, 16'h0);
        tbl[5]  = mk(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0,
                     1'b0, 1'b0, 1'b1, 16'hBEEF, 1'b0, 16'h0, 16'h0);
        tbl[6]  = mk(1'b1, 1'b0, 16'h20, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0,
                     1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h20, 16'h0);
        tbl[7]  = mk(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 16'h50, 16'h5555,
                     1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h1234);
        tbl[8]  = mk(1'b1, 1'b0, 16'h22, 16'h0, 1'b1, 1'b1, 16'h50, 16'h5555,
                     1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 16'h50, 16'h1234);
        tbl[9]  = mk(1'b1, 1'b0, 16'h22, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0,
                     1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h22, 16'h1234);
        tbl[10] = mk(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h50, 16'h0,
                     1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
        tbl[11] = mk(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h50, 16'h0,
                     1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h50, 16'h0);
        tbl[12] = mk(1'b1, 1'b1, 16'h30, 16'hA5A5, 1'b0, 1'b0, 16'h0, 16'h0,
                     1'b0, 1'b0, 1'b1, 16'h5555, 1'b1, 16'h30, 16'h0);
        tbl[13] = mk(1'b1, 1'b0, 16'h30, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0,
                     1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h30, 16'h0);
        tbl[14] = mk(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0,
                     1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'hA5A5);

        for (int i = 0; i < 15; i++) begin
            cpu_req = tbl[i].cr; cpu_wen = tbl[i].cw;
            cpu_addr = tbl[i].ca; cpu_wdata = tbl[i].cd;
            ext_req = tbl[i].er; ext_wen = tbl[i].ew;
            ext_addr = tbl[i].ea; ext_wdata = tbl[i].ed;
            @(negedge clk);
            chk($sformatf("v%0d_gnt", i), b16(ext_gnt), b16(tbl[i].gnt));
            chk($sformatf("v%0d_stall", i), b16(cpu_stall), b16(tbl[i].stall));
            chk($sformatf("v%0d_rvalid", i), b16(ext_rvalid), b16(tbl[i].rv));
            chk($sformatf("v%0d_ext_rdata", i), ext_rdata, tbl[i].erd);
            chk($sformatf("v%0d_mem_wen", i), b16(mem_wen), b16(tbl[i].mwen));
            chk($sformatf("v%0d_mem_addr", i), mem_addr, tbl[i].maddr);
            chk($sformatf("v%0d_cpu_rdata", i), cpu_rdata, tbl[i].crd);
            @(posedge clk); #1;
        end

        // Sustained contention: CPU reads 0x20, ext writes 0x70
        cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 16'h20; cpu_wdata = '0;
        ext_req = 1'b1; ext_wen = 1'b1; ext_addr = 16'h70; ext_wdata = 16'h0707;
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            chk($sformatf("c%0d_gnt", k), b16(ext_gnt), b16((k % 6) == 5));
            chk($sformatf("c%0d_stall", k), b16(cpu_stall), b16((k % 6) == 5));
            chk($sformatf("c%0d_gnt0", k), b16(ext_gnt0), b16((k % 2) == 1));
            chk($sformatf("c%0d_overlap0", k), b16(ext_gnt0 & cpu_req & ~cpu_stall0), 16'h0);
            if (k >= 1) chk($sformatf("c%0d_cpu_rdata", k), cpu_rdata, 16'h1234);
            @(posedge clk); #1;
        end

        // Reset while an ext write is being issued
        cpu_req = 1'b0; cpu_wen = 1'b0; cpu_addr = '0;
        ext_req = 1'b1; ext_wen = 1'b1; ext_addr = 16'h60; ext_wdata = 16'h7777;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_mem_wen", b16(mem_wen), 16'h0);
        chk("mid_rst_gnt", b16(ext_gnt), 16'h0);
        chk("mid_rst_stall", b16(cpu_stall), 16'h0);
        chk("mid_rst_rvalid", b16(ext_rvalid), 16'h0);
        chk("mid_rst_ext_rdata", ext_rdata, 16'h0);
        chk("mid_rst_cpu_rdata", cpu_rdata, 16'h0);
        chk("mid_rst_mem_addr", mem_addr, 16'h0);
        @(posedge clk); #1;
        rst = 1'b0; ext_req = 1'b0;
        cpu_req = 1'b1; cpu_addr = 16'h60;
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_addr = '0;
        @(negedge clk);
        chk("mid_rst_no_write", cpu_rdata, 16'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Randomized traffic against the reference model
        slot = 1'b0; slot_wen = 1'b0; slot_addr = '0; slot_wd = '0;
        eret = 1'b0; eret_d = '0; cret = 1'b0; cret_d = '0; clast = '0; lost = 0;
        for (int i = 0; i < 256; i++) shadow[i] = '0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            e_stall = slot & cpu_req;
            chk("rnd_gnt", b16(ext_gnt), b16(slot));
            chk("rnd_stall", b16(cpu_stall), b16(e_stall));
            chk("rnd_rvalid", b16(ext_rvalid), b16(eret));
            chk("rnd_ext_rdata", ext_rdata, eret ? eret_d : 16'h0);
            chk("rnd_cpu_rdata", cpu_rdata, cret ? cret_d : clast);
            chk("rnd_mem_wen", b16(mem_wen), b16(slot ? slot_wen : (cpu_req & cpu_wen)));
            chk("rnd_mem_addr", mem_addr, slot ? slot_addr : cpu_addr);
            @(posedge clk);
            was_slot = slot;
            if (cret) clast = cret_d;
            n_cret   = ~slot & cpu_req & ~cpu_wen;
            n_cret_d = shadow[cpu_addr[7:0]];
            n_eret   = slot & ~slot_wen;
            n_eret_d = shadow[slot_addr[7:0]];
            n_slot   = 1'b0;
            if (slot) begin
                if (slot_wen) shadow[slot_addr[7:0]] = slot_wd;
            end else begin
                if (cpu_req & cpu_wen) shadow[cpu_addr[7:0]] = cpu_wdata;
                if (ext_req && (!cpu_req || lost == MW)) begin
                    n_slot = 1'b1;
                    slot_wen = ext_wen; slot_addr = ext_addr; slot_wd = ext_wdata;
                    lost = 0;
                end else if (ext_req && cpu_req) begin
                    lost = (lost < MW) ? lost + 1 : MW;
                end else begin
                    lost = 0;
                end
            end
            slot = n_slot; eret = n_eret; eret_d = n_eret_d;
            cret = n_cret; cret_d = n_cret_d;
            #1;
            if (!(cpu_req && e_stall)) begin
                cpu_req   = ($urandom_range(0, 99) < 60);
                cpu_wen   = $urandom_range(0, 1) == 1;
                cpu_addr  = 16'h0080 + 16'($urandom_range(0, 15));
                cpu_wdata = 16'($urandom);
            end
            if (!(ext_req && !was_slot)) begin
                ext_req   = ($urandom_range(0, 99) < 40);
                ext_wen   = $urandom_range(0, 1) == 1;
                ext_addr  = 16'h0080 + 16'($urandom_range(0, 15));
                ext_wdata = 16'($urandom);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
